// File: rtl/spu32_cpu_seqshifter.sv
// spu32 multi-cycle shifter: up to STEP positions per cycle, valid/ready on both sides.
// Define SPU32_SHIFTER_ROTATE_EN to build ROR for op 11 (otherwise op 11 acts as SRL).
module spu32_cpu_seqshifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic                     I_clk,
  input  logic                     I_reset_n,
  input  logic                     I_valid,
  output logic                     O_ready,
  input  logic [WIDTH-1:0]         I_data,
  input  logic [$clog2(WIDTH)-1:0] I_shift,
  input  logic [1:0]               I_op,
  output logic                     O_valid,
  input  logic                     I_ready,
  output logic [WIDTH-1:0]         O_data
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW:0] STEP_X = (SW+1)'(STEP);
  localparam logic [WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  logic [SW-1:0]   rem;
  logic [1:0]      op;
  logic            sign;
  logic [SW:0]     rem_x;
  logic [SW:0]     k;
  logic [WIDTH-1:0] step_res;

  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       o,
    input logic             sg,
    input int               n
  );
    logic [WIDTH-1:0] r;
    r = d >> n;
    case (o)
      2'b00: r = d << n;
      2'b10: r = (d >> n) | (sg ? ~(ONES >> n) : '0);
`ifdef SPU32_SHIFTER_ROTATE_EN
      2'b11: r = (d >> n) | (d << (WIDTH - n));
`endif
      default: r = d >> n;
    endcase
    return r;
  endfunction

  assign rem_x = {1'b0, rem};
  assign k = (rem_x < STEP_X) ? rem_x : STEP_X;

  // Only constant shifts 1..STEP exist; k picks one of them.
  always_comb begin
    step_res = O_data;
    for (int j = 1; j <= STEP; j++) begin
      if (k == (SW+1)'(j)) begin
        step_res = shift_by(O_data, op, sign, j);
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state   <= IDLE;
      O_ready <= 1'b1;
      O_valid <= 1'b0;
      O_data  <= '0;
      rem     <= '0;
      op      <= 2'b00;
      sign    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (I_valid) begin
            O_data  <= I_data;
            op      <= I_op;
            rem     <= I_shift;
            sign    <= I_data[WIDTH-1];
            O_ready <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (rem == '0) begin
            O_valid <= 1'b1;
            state   <= DONE;
          end else begin
            O_data <= step_res;
            rem    <= rem - k[SW-1:0];
          end
        end
        DONE: begin
          if (I_ready) begin
            O_valid <= 1'b0;
            O_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          O_valid <= 1'b0;
          O_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spu32_cpu_seqshifter.sv
// Bench for spu32_cpu_seqshifter: vector table, corner sequences, random sweeps.
// Second instance runs the STEP=WIDTH configuration.
module tb_spu32_cpu_seqshifter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid, a_oready, a_ovalid, a_ready;
  logic [31:0] a_data, a_odata;
  logic [4:0]  a_shift;
  logic [1:0]  a_op;

  logic        w_valid, w_oready, w_ovalid, w_ready;
  logic [31:0] w_data, w_odata;
  logic [4:0]  w_shift;
  logic [1:0]  w_op;

  spu32_cpu_seqshifter #(.WIDTH(32), .STEP(4)) u_dut (
    .I_clk(clk), .I_reset_n(rst_n),
    .I_valid(a_valid), .O_ready(a_oready),
    .I_data(a_data), .I_shift(a_shift), .I_op(a_op),
    .O_valid(a_ovalid), .I_ready(a_ready), .O_data(a_odata)
  );

  spu32_cpu_seqshifter #(.WIDTH(32), .STEP(32)) u_wide (
    .I_clk(clk), .I_reset_n(rst_n),
    .I_valid(w_valid), .O_ready(w_oready),
    .I_data(w_data), .I_shift(w_shift), .I_op(w_op),
    .O_valid(w_ovalid), .I_ready(w_ready), .O_data(w_odata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op,
                                         input logic [31:0] d,
                                         input int s);
    case (op)
      2'b00: return d << s;
      2'b01: return d >> s;
      2'b10: return 32'($signed(d) >>> s);
`ifdef SPU32_SHIFTER_ROTATE_EN
      default: return (d >> s) | (d << (32 - s));
`else
      default: return d >> s;
`endif
    endcase
  endfunction

  function automatic int ref_lat(input int s, input int step);
    return 1 + (s + step - 1) / step;
  endfunction

  task automatic do_op(input bit wide, input logic [1:0] op,
                       input logic [31:0] d, input logic [4:0] s,
                       input bit consume,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    chk("idle_ready", wide ? w_oready : a_oready, 1'b1);
    if (wide) begin
      w_valid = 1; w_data = d; w_shift = s; w_op = op;
    end else begin
      a_valid = 1; a_data = d; a_shift = s; a_op = op;
    end
    @(posedge clk); #1;
    if (wide) begin
      w_valid = 0; w_data = ~d; w_shift = ~s; w_op = ~op;
    end else begin
      a_valid = 0; a_data = ~d; a_shift = ~s; a_op = ~op;
    end
    lat = 0;
    while (!(wide ? w_ovalid : a_ovalid) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      chk("busy_ready", wide ? w_oready : a_oready, 1'b0);
    end
    res = wide ? w_odata : a_odata;
    if (consume) begin
      if (wide) w_ready = 1; else a_ready = 1;
      @(posedge clk); #1;
      if (wide) w_ready = 0; else a_ready = 0;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] d;
    logic [4:0]  s;
    logic [31:0] exp;
    int          lat;
  } vec_t;

`ifdef SPU32_SHIFTER_ROTATE_EN
  localparam logic [31:0] ROR_EXP = 32'h78123456;
`else
  localparam logic [31:0] ROR_EXP = 32'h00123456;
`endif

  vec_t tbl[10];

  initial begin
    logic [31:0] res;
    logic [31:0] d;
    logic [1:0]  op;
    int lat;
    int s;

    tbl[0] = '{2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 9};
    tbl[1] = '{2'b00, 32'h00000001, 5'd5,  32'h00000020, 3};
    tbl[2] = '{2'b01, 32'h80000000, 5'd5,  32'h04000000, 3};
    tbl[3] = '{2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
    tbl[4] = '{2'b10, 32'h7FFFFFF0, 5'd4,  32'h07FFFFFF, 2};
    tbl[5] = '{2'b10, 32'hF0000000, 5'd8,  32'hFFF00000, 3};
    tbl[6] = '{2'b11, 32'h12345678, 5'd8,  ROR_EXP,      3};
    tbl[7] = '{2'b01, 32'hFFFFFFFF, 5'd31, 32'h00000001, 9};
    tbl[8] = '{2'b00, 32'hFFFFFFFF, 5'd31, 32'h80000000, 9};
    tbl[9] = '{2'b10, 32'h12345678, 5'd0,  32'h12345678, 1};

    a_valid = 0; a_ready = 0; a_data = 0; a_shift = 0; a_op = 0;
    w_valid = 0; w_ready = 0; w_data = 0; w_shift = 0; w_op = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", a_oready, 1'b1);
    chk("rst_valid", a_ovalid, 1'b0);
    chk("rst_data", a_odata, 32'h0);
    chk("rst_w_ready", w_oready, 1'b1);
    @(negedge clk);
    rst_n = 1;

    foreach (tbl[i]) begin
      do_op(1'b0, tbl[i].op, tbl[i].d, tbl[i].s, 1'b1, res, lat);
      chk($sformatf("vec%0d_data", i), res, tbl[i].exp);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // backpressure: result held while new requests are offered
    do_op(1'b0, 2'b00, 32'h1, 5'd5, 1'b0, res, lat);
    chk("bp_first", res, 32'h20);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_valid = (c != 1);
      a_data = 32'hAAAA5555;
      a_shift = 5'd3;
      a_op = 2'b01;
      @(posedge clk); #1;
      chk("bp_data", a_odata, 32'h20);
      chk("bp_valid", a_ovalid, 1'b1);
      chk("bp_ready", a_oready, 1'b0);
    end
    @(negedge clk);
    a_valid = 1;
    a_ready = 1;
    @(posedge clk); #1;
    a_valid = 0;
    a_ready = 0;
    chk("bp_rel_valid", a_ovalid, 1'b0);
    chk("bp_rel_ready", a_oready, 1'b1);
    @(posedge clk); #1;
    chk("bp_no_accept", a_oready, 1'b1);

    // reset while busy
    @(negedge clk);
    a_valid = 1; a_data = 32'hCAFEF00D; a_shift = 5'd28; a_op = 2'b01;
    @(posedge clk); #1;
    a_valid = 0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", a_ovalid, 1'b0);
    chk("mid_rst_ready", a_oready, 1'b1);
    chk("mid_rst_data", a_odata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    do_op(1'b0, 2'b10, 32'h80000000, 5'd28, 1'b1, res, lat);
    chk("post_rst_data", res, 32'hFFFFFFF8);
    chk("post_rst_lat", 32'(lat), 32'd8);

    for (int i = 0; i < 40; i++) begin
      d = $urandom;
      op = 2'($urandom_range(0, 3));
      s = $urandom_range(0, 31);
      do_op(1'b0, op, d, 5'(s), 1'b1, res, lat);
      chk("rnd_data", res, ref_op(op, d, s));
      chk("rnd_lat", 32'(lat), 32'(ref_lat(s, 4)));
    end

    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      op = 2'($urandom_range(0, 3));
      s = $urandom_range(1, 31);
      do_op(1'b1, op, d, 5'(s), 1'b1, res, lat);
      chk("wide_data", res, ref_op(op, d, s));
      chk("wide_lat", 32'(lat), 32'd2);
    end

    do_op(1'b1, 2'b01, 32'h89ABCDEF, 5'd0, 1'b1, res, lat);
    chk("wide_s0_data", res, 32'h89ABCDEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
